// File: rtl/lsu_bus_adapter.sv
// Load/store adapter from the core data-memory request to a valid/ready bus with variable latency.
// Optional LSU_TIMEOUT_EN: abort with core_err after TIMEOUT_CYCLES cycles in REQ/WAIT.
module lsu_bus_adapter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_valid,
   input  logic              core_we,
   input  logic [1:0]        core_size,
   input  logic              core_sign,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_stall,
   output logic              core_done,
   output logic [31:0]       core_rdata,
   output logic              core_err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rsp_valid,
   input  logic [31:0]       bus_rsp_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic              bus_req_valid_q, bus_req_valid_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              core_done_q, core_done_d;
   logic [31:0]       core_rdata_q, core_rdata_d;
   logic              core_err_q, core_err_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;

   logic              req_legal;
   logic [3:0]        req_be;
   logic [31:0]       req_wdata;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       rsp_fmt;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      req_legal = 1'b0;
      req_be    = '0;
      req_wdata = '0;
      case (core_size)
         2'b00: begin
            req_legal = 1'b1;
            req_be    = 4'b0001 << core_addr[1:0];
            req_wdata = {4{core_wdata[7:0]}};
         end
         2'b01: begin
            req_legal = ~core_addr[0];
            req_be    = core_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{core_wdata[15:0]}};
         end
         2'b10: begin
            req_legal = (core_addr[1:0] == 2'b00);
            req_be    = 4'b1111;
            req_wdata = core_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo_q)
         2'd0:    lane_b = bus_rsp_rdata[7:0];
         2'd1:    lane_b = bus_rsp_rdata[15:8];
         2'd2:    lane_b = bus_rsp_rdata[23:16];
         default: lane_b = bus_rsp_rdata[31:24];
      endcase
      lane_h = addr_lo_q[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
      case (size_q)
         2'b00:   rsp_fmt = {{24{sign_q & lane_b[7]}}, lane_b};
         2'b01:   rsp_fmt = {{16{sign_q & lane_h[15]}}, lane_h};
         default: rsp_fmt = bus_rsp_rdata;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      bus_req_valid_d = bus_req_valid_q;
      bus_we_d        = bus_we_q;
      bus_addr_d      = bus_addr_q;
      bus_be_d        = bus_be_q;
      bus_wdata_d     = bus_wdata_q;
      core_done_d     = 1'b0;
      core_rdata_d    = core_rdata_q;
      core_err_d      = core_err_q;
      addr_lo_d       = addr_lo_q;
      size_d          = size_q;
      sign_d          = sign_q;
      case (state_q)
         IDLE: begin
            if (core_valid) begin
               if (req_legal) begin
                  state_d         = REQ;
                  bus_req_valid_d = 1'b1;
                  bus_we_d        = core_we;
                  bus_addr_d      = {core_addr[ADDR_W-1:2], 2'b00};
                  bus_be_d        = req_be;
                  bus_wdata_d     = req_wdata;
                  addr_lo_d       = core_addr[1:0];
                  size_d          = core_size;
                  sign_d          = core_sign;
               end else begin
                  state_d      = DONE;
                  core_done_d  = 1'b1;
                  core_err_d   = 1'b1;
                  core_rdata_d = '0;
               end
            end
         end
         REQ: begin
            if (bus_req_ready) begin
               state_d         = WAIT;
               bus_req_valid_d = 1'b0;
            end
         end
         WAIT: begin
            if (bus_rsp_valid) begin
               state_d      = DONE;
               core_done_d  = 1'b1;
               core_err_d   = 1'b0;
               core_rdata_d = bus_we_q ? '0 : rsp_fmt;
            end
         end
         default: begin
            state_d    = IDLE;
            core_err_d = 1'b0;
         end
      endcase
`ifdef LSU_TIMEOUT_EN
      // Counter is cleared throughout IDLE, so it starts from zero on every REQ entry.
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == REQ || (state_q == WAIT && !bus_rsp_valid)) begin
         if (cnt_q == TMO_LAST) begin
            state_d         = DONE;
            bus_req_valid_d = 1'b0;
            core_done_d     = 1'b1;
            core_err_d      = 1'b1;
            core_rdata_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         bus_req_valid_q <= 1'b0;
         bus_we_q        <= 1'b0;
         bus_addr_q      <= '0;
         bus_be_q        <= '0;
         bus_wdata_q     <= '0;
         core_done_q     <= 1'b0;
         core_rdata_q    <= '0;
         core_err_q      <= 1'b0;
         addr_lo_q       <= '0;
         size_q          <= '0;
         sign_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         bus_req_valid_q <= bus_req_valid_d;
         bus_we_q        <= bus_we_d;
         bus_addr_q      <= bus_addr_d;
         bus_be_q        <= bus_be_d;
         bus_wdata_q     <= bus_wdata_d;
         core_done_q     <= core_done_d;
         core_rdata_q    <= core_rdata_d;
         core_err_q      <= core_err_d;
         addr_lo_q       <= addr_lo_d;
         size_q          <= size_d;
         sign_q          <= sign_d;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

   assign core_stall    = (state_q == IDLE && core_valid) || state_q == REQ || state_q == WAIT;
   assign core_done     = core_done_q;
   assign core_rdata    = core_rdata_q;
   assign core_err      = core_err_q;
   assign bus_req_valid = bus_req_valid_q;
   assign bus_we        = bus_we_q;
   assign bus_addr      = bus_addr_q;
   assign bus_be        = bus_be_q;
   assign bus_wdata     = bus_wdata_q;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Self-checking bench for lsu_bus_adapter: directed scenarios plus randomized transactions vs a byte-level model.
module tb_lsu_bus_adapter;
   logic        clk = 1'b0;
   logic        rst;
   logic        core_valid, core_we, core_sign;
   logic [1:0]  core_size;
   logic [31:0] core_addr, core_wdata;
   logic        core_stall, core_done, core_err;
   logic [31:0] core_rdata;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations gathered by the bus/core driver for the current transaction
   int          obs_req_cycles, obs_done_cyc;
   bit          obs_stable, obs_got_done, obs_stall_ok, obs_done_prev;
   logic        obs_we, obs_err;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_be;

   always #5 clk = ~clk;

   lsu_bus_adapter #(.ADDR_W(32), .TIMEOUT_CYCLES(256)) dut (
      .clk(clk), .rst(rst),
      .core_valid(core_valid), .core_we(core_we), .core_size(core_size), .core_sign(core_sign),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   function automatic int unsigned nbytes(input logic [1:0] s);
      return 32'd1 << s;
   endfunction

   function automatic bit m_legal(input logic [1:0] s, input logic [31:0] a);
      if (s == 2'b11) return 1'b0;
      return (a % nbytes(s)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
      int unsigned m;
      m = ((32'd1 << nbytes(s)) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
      if (nbytes(s) == 1) return (w & 32'hFF) * 32'h0101_0101;
      if (nbytes(s) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_rdata(input logic we, input logic [1:0] s, input logic sg,
                                            input logic [31:0] a, input logic [31:0] r);
      longint unsigned v;
      int unsigned nb;
      if (we || !m_legal(s, a)) return 32'h0;
      nb = 8 * nbytes(s);
      v  = ({32'h0, r} >> (8 * (a % 4))) & ((64'd1 << nb) - 1);
      if (sg && nb < 32 && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
      return v[31:0];
   endfunction

   // Drives one core request and plays the bus: ready after rdy_dly valid cycles,
   // response rsp_lat cycles after acceptance; noise pulses rsp_valid while in REQ.
   task automatic run_txn(input logic we, input logic [1:0] size, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int rdy_dly, input int rsp_lat, input bit noise);
      int  wait_cyc;
      bit  accepted;
      @(negedge clk);
      obs_done_prev = core_done;
      core_valid = 1'b1; core_we = we; core_size = size; core_sign = sg;
      core_addr = addr; core_wdata = wdata;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = rdata;
      #1;
      obs_stall_ok = (core_stall === 1'b1);
      obs_req_cycles = 0; obs_stable = 1'b1; obs_got_done = 1'b0; obs_done_cyc = -1;
      obs_rdata = 'x; obs_err = 1'bx;
      accepted = 1'b0; wait_cyc = 0;
      for (int cyc = 1; cyc <= 60 && !obs_got_done; cyc++) begin
         @(negedge clk);
         bus_rsp_valid = 1'b0;
         bus_rsp_rdata = rdata;
         if (core_done === 1'b1) begin
            obs_got_done = 1'b1; obs_done_cyc = cyc;
            obs_rdata = core_rdata; obs_err = core_err;
            if (core_stall !== 1'b0) obs_stall_ok = 1'b0;
            bus_req_ready = 1'b0;
            core_valid = 1'b0;
         end else begin
            if (core_stall !== 1'b1) obs_stall_ok = 1'b0;
            if (bus_req_valid === 1'b1) begin
               if (obs_req_cycles == 0) begin
                  obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;
               end else if (bus_we !== obs_we || bus_addr !== obs_addr || bus_be !== obs_be ||
                            bus_wdata !== obs_wdata) begin
                  obs_stable = 1'b0;
               end
               obs_req_cycles++;
               bus_req_ready = (obs_req_cycles > rdy_dly);
               if (bus_req_ready) accepted = 1'b1;
               else if (noise) begin
                  bus_rsp_valid = 1'b1;
                  bus_rsp_rdata = ~rdata;
               end
            end else begin
               bus_req_ready = 1'b0;
               if (accepted) begin
                  wait_cyc++;
                  if (wait_cyc == rsp_lat) bus_rsp_valid = 1'b1;
               end
            end
         end
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_size = 2'b00; core_sign = 1'b0;
      core_addr = '0; core_wdata = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata, core_done, core_rdata, core_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h done=%b rd=%h err=%b exp all 0",
                  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata, core_done, core_rdata, core_err);
      end
      n_checks++;
      if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", core_stall); end
      rst = 1'b0;
   endtask

   task automatic test_store_byte();
      run_txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 2, 1'b0);
      n_checks++;
      if (obs_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got %h exp 00001000", obs_addr); end
      n_checks++;
      if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b exp 1000", obs_be); end
      n_checks++;
      if (obs_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata got %h exp a5a5a5a5", obs_wdata); end
      n_checks++;
      if (obs_we !== 1'b1) begin n_fail++; $display("FAIL sb_we got %b exp 1", obs_we); end
      n_checks++;
      if (obs_done_cyc !== 4) begin n_fail++; $display("FAIL sb_done_cycle got %0d exp 4", obs_done_cyc); end
      n_checks++;
      if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
         n_fail++; $display("FAIL sb_err_rdata got err=%b rd=%h exp err=0 rd=0", obs_err, obs_rdata);
      end
      n_checks++;
      if (!obs_stall_ok) begin n_fail++; $display("FAIL sb_stall got bad stall profile exp high until DONE"); end
      @(negedge clk);
      n_checks++;
      if (core_done !== 1'b0 || core_stall !== 1'b0) begin
         n_fail++; $display("FAIL sb_done_pulse got done=%b stall=%b exp 0 0", core_done, core_stall);
      end
   endtask

   task automatic test_load_half();
      run_txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 1'b0);
      n_checks++;
      if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got %b exp 1100", obs_be); end
      n_checks++;
      if (obs_rdata !== 32'hFFFF_8001 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL lh_signed got rd=%h err=%b exp ffff8001 0", obs_rdata, obs_err);
      end
      run_txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 1'b0);
      n_checks++;
      if (obs_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lh_unsigned got %h exp 00008001", obs_rdata); end
   endtask

   task automatic test_illegal();
      logic [1:0] sz [2] = '{2'b10, 2'b11};
      logic [31:0] ad [2] = '{32'h0000_3001, 32'h0000_3000};
      for (int i = 0; i < 2; i++) begin
         run_txn(1'b0, sz[i], 1'b0, ad[i], 32'h0, 32'h1234_5678, 0, 1, 1'b0);
         n_checks++;
         if (obs_req_cycles != 0 || obs_done_cyc != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_%0d got req_cycles=%0d done_cyc=%0d err=%b rd=%h exp 0 1 1 0",
                     i, obs_req_cycles, obs_done_cyc, obs_err, obs_rdata);
         end
      end
   endtask

   task automatic test_backpressure();
      run_txn(1'b0, 2'b10, 1'b1, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 5, 2, 1'b1);
      n_checks++;
      if (obs_req_cycles != 6 || !obs_stable) begin
         n_fail++; $display("FAIL bp_hold got cycles=%0d stable=%0d exp 6 1", obs_req_cycles, obs_stable);
      end
      n_checks++;
      if (obs_rdata !== 32'hCAFE_F00D || obs_done_cyc != 9) begin
         n_fail++; $display("FAIL bp_result got rd=%h done_cyc=%0d exp cafef00d 9", obs_rdata, obs_done_cyc);
      end
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'h0, 32'h0000_F000, 0, 1, 1'b0);
      n_checks++;
      if (obs_rdata !== 32'hFFFF_FFF0 || obs_done_cyc != 3) begin
         n_fail++; $display("FAIL b2b_first got rd=%h done_cyc=%0d exp fffffff0 3", obs_rdata, obs_done_cyc);
      end
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_6006, 32'h1234_BEEF, 32'h0, 0, 1, 1'b0);
      n_checks++;
      if (obs_done_prev !== 1'b0 || obs_req_cycles != 1 || obs_done_cyc != 3) begin
         n_fail++; $display("FAIL b2b_second got prev_done=%b req_cycles=%0d done_cyc=%0d exp 0 1 3",
                            obs_done_prev, obs_req_cycles, obs_done_cyc);
      end
      n_checks++;
      if (obs_addr !== 32'h0000_6004 || obs_be !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_we !== 1'b1) begin
         n_fail++; $display("FAIL b2b_fields got addr=%h be=%b wd=%h we=%b exp 00006004 1100 beefbeef 1",
                            obs_addr, obs_be, obs_wdata, obs_we);
      end
   endtask

   task automatic test_random();
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a, w, r;
      int          rd, lt;
      bit          ok;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
         a = $urandom; w = $urandom; r = $urandom;
         rd = int'($urandom_range(0, 3)); lt = int'($urandom_range(1, 3));
         run_txn(we, sz, sg, a, w, r, rd, lt, 1'($urandom));
         n_checks++;
         if (m_legal(sz, a)) begin
            ok = obs_got_done && obs_req_cycles == rd + 1 && obs_stable && obs_stall_ok &&
                 obs_we === we && obs_addr === (a & 32'hFFFF_FFFC) && obs_be === m_be(sz, a) &&
                 obs_wdata === m_wdata(sz, w) && obs_done_cyc == 2 + rd + lt &&
                 obs_err === 1'b0 && obs_rdata === m_rdata(we, sz, sg, a, r);
         end else begin
            ok = obs_got_done && obs_req_cycles == 0 && obs_done_cyc == 1 &&
                 obs_err === 1'b1 && obs_rdata === 32'h0;
         end
         if (!ok) begin
            n_fail++;
            $display("FAIL rand_%0d we=%b sz=%b sg=%b a=%h: got req=%0d addr=%h be=%b wd=%h done_cyc=%0d err=%b rd=%h exp be=%b wd=%h done_cyc=%0d rd=%h legal=%0d",
                     i, we, sz, sg, a, obs_req_cycles, obs_addr, obs_be, obs_wdata, obs_done_cyc, obs_err,
                     obs_rdata, m_be(sz, a), m_wdata(sz, w), 2 + rd + lt, m_rdata(we, sz, sg, a, r), m_legal(sz, a));
         end
      end
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      @(negedge clk);
      core_valid = 1'b1; core_we = 1'b0; core_size = 2'b10; core_sign = 1'b0;
      core_addr = 32'h0000_7000; bus_rsp_rdata = 32'h1111_2222;
      @(negedge clk);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0; rst = 1'b1; core_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; bus_rsp_valid = 1'b1;
      n_checks++;
      if (bus_req_valid !== 1'b0 || core_stall !== 1'b0) begin
         n_fail++; $display("FAIL rmid_idle got req=%b stall=%b exp 0 0", bus_req_valid, core_stall);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_rsp_valid = 1'b0;
         if (core_done !== 1'b0) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin n_fail++; $display("FAIL rmid_no_done got done pulse exp none"); end
      n_checks++;
      if ({bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata, core_done, core_rdata, core_err} !== '0) begin
         n_fail++;
         $display("FAIL rmid_outputs got req=%b we=%b addr=%h be=%b wd=%h done=%b rd=%h err=%b exp all 0",
                  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata, core_done, core_rdata, core_err);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no completion exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_byte();
      test_load_half();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
